// File: rtl/sum_sched_pkg.sv
// sum_sched_pkg: shared defaults, FSM state type and round-robin helpers for summation_scheduler
package sum_sched_pkg;
  localparam int NW_DEF = 4;
  localparam int SW_DEF = 7;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int rr_next(input int idx, input int nreq);
    return (idx + 1 >= nreq) ? 0 : idx + 1;
  endfunction
  // Scans downward so the lowest offset from ptr is the last one written and wins.
  function automatic int rr_pick(input logic [31:0] req, input int ptr, input int nreq);
    int idx;
    rr_pick = ptr;
    for (int k = 31; k >= 0; k--) begin
      if (k < nreq) begin
        idx = ptr + k;
        if (idx >= nreq) idx = idx - nreq;
        if (req[idx]) rr_pick = idx;
      end
    end
  endfunction
endpackage

// File: rtl/summation_core.sv
// summation_core: iterative accumulator, adds cnt into acc and counts cnt down to zero
module summation_core import sum_sched_pkg::*; #(
  parameter int NW = NW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] n,
  output logic          zero,
  output logic [SW-1:0] acc
);
  logic [NW-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= '0;
      cnt <= n;
    end else if (!zero) begin
      acc <= acc + SW'(cnt);
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/summation_scheduler.sv
// summation_scheduler: round-robin sharing of one summation_core among NREQ requesters
// Optional SUM_SCHED_STATS_EN adds the saturating job_cnt output.
module summation_scheduler import sum_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int NW   = NW_DEF,
  parameter int SW   = SW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*NW-1:0] n_in,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic [SW-1:0]      sum_out,
`ifdef SUM_SCHED_STATS_EN
  output logic               busy,
  output logic [15:0]        job_cnt
`else
  output logic               busy
`endif
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t state;
  logic [PW-1:0] rr, owner, pick;
  logic [NW-1:0] n_pick;
  logic [SW-1:0] acc;
  logic start, zero;
  assign pick   = PW'(rr_pick(32'(req), int'(rr), NREQ));
  assign n_pick = n_in[pick*NW +: NW];
  assign start  = (state == IDLE) && |req;
  summation_core #(.NW(NW), .SW(SW)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .n     (n_pick),
    .zero  (zero),
    .acc   (acc)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr      <= '0;
      owner   <= '0;
      grant   <= '0;
      done    <= '0;
      sum_out <= '0;
      busy    <= 1'b0;
    end else begin
      grant <= '0;
      done  <= '0;
      case (state)
        IDLE: if (start) begin
          grant <= NREQ'(1) << pick;
          owner <= pick;
          busy  <= 1'b1;
          rr    <= PW'(rr_next(int'(pick), NREQ));
          state <= RUN;
        end
        RUN: if (zero) begin
          sum_out <= acc;
          done    <= NREQ'(1) << owner;
          state   <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SUM_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) job_cnt <= '0;
    else if (state == RUN && zero && job_cnt != 16'hFFFF) job_cnt <= job_cnt + 16'd1;
  end
`endif
endmodule
